if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage with a prefetch queue. It replaces the single-register IF stage: it keeps fetching from the SPM while the IF/ID register is stalled, and it supports separate flush and branch redirects. It sits between the SPM port A and the IF/ID pipeline register, and drives `if_pc`, `if_pc_plus4`, `if_insn` and `if_en` into `id_stage`.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, 2..16.
- `RESET_VECTOR`, 32'h0: first fetch address; must be word aligned.
- `NOP_INSN`, 32'h00000013: bubble instruction, equal to `ISA_NOP`.
- `clk` in 1: clock; single clock domain. Active-high asynchronous reset, as are all registers.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hold the IF/ID register.
- `flush` in 1: discard all in-flight fetches and redirect to `new_pc`.
- `new_pc` in 32: flush target.
- `br_taken` in 1: branch redirect to `br_addr`.
- `br_addr` in 32: branch target.
- `spm_rd_data` in 32: SPM read data, valid in the same cycle as the strobe (SPM runs on `clk_`).
- `spm_addr` out 30: word address, `fpc[31:2]`.
- `spm_as_` out 1: address strobe, active low.
- `spm_rw` out 1: constant READ.
- `spm_wr_data` out 32: constant 0.
- `if_pc` out 32: PC of the instruction in IF/ID.
- `if_pc_plus4` out 32: `if_pc` + 4.
- `if_insn` out 32: instruction in IF/ID.
- `if_en` out 1: IF/ID contents valid.
- `fq_count` out clog2(DEPTH+1): queue occupancy.

## Operation
- State:
  - fetch PC `fpc`;
  - circular queue of {pc, insn}, with wrapping read/write pointers and a count;
  - IF/ID register.
- Definitions:
  - `pop` = `!stall` && count>0.
  - `issue` = `!reset` && `!flush` && `!br_taken` && (count<DEPTH || `pop`).
- Issue: when `issue` is true, `spm_as_`=0 and `spm_addr`=`fpc[31:2]`. At the edge, `fpc` += 4 (32-bit wrap).
- Destination of fetched data, in priority order:
  - IF/ID register directly (bypass), when count==0 && `!stall`;
  - otherwise queue tail.
- IF/ID update when `!stall`:
  - head of queue if count>0;
  - else bypass data;
  - else a bubble: `if_en`=0, `if_insn`=NOP_INSN, `if_pc` and `if_pc_plus4` unchanged.
- IF/ID update when `stall`: IF/ID holds every field.
- Priority: `flush` > `br_taken` > `stall` > normal.
- `flush`:
  - queue cleared (count=0, pointers reset);
  - IF/ID becomes a bubble;
  - `fpc` <= {`new_pc[31:2]`,2'b00};
  - no issue in that cycle.
- `br_taken` (without `flush`): same action, target `br_addr`. It overrides `stall`.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Ordering: instructions leave the block strictly in fetch order and never duplicate.

## Timing
- Reset values:
  - `fpc`=RESET_VECTOR, count=0, pointers=0;
  - `if_pc`=RESET_VECTOR, `if_pc_plus4`=RESET_VECTOR+4;
  - `if_insn`=NOP_INSN, `if_en`=0, `fq_count`=0;
  - `spm_as_`=1, combinationally forced while `reset` is high.
- Latency: fetch to `if_en`=1 is 1 edge on the bypass path. With the queue non-empty, it is 1 edge per queued entry ahead.
- Throughput: 1 instruction per cycle when unstalled.
- Redirect: after the redirect edge `if_en`=0. The target instruction appears in IF/ID on the next edge, 2 edges after assertion.
- Full queue with `stall` high: `spm_as_`=1, `fpc` holds.
- First unstalled cycle on a full queue: pop and issue together, count stays DEPTH.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight strobe is dropped.

## Test plan
- Reset release, SPM word0=32'h00400093, word1=32'h40102023 -> edge 1: `if_pc`=0, `if_insn`=32'h00400093, `if_en`=1. Edge 2: `if_pc`=4, `if_pc_plus4`=8, `if_insn`=32'h40102023.
- `stall` held 6 cycles, DEPTH=4 -> `fq_count` 1,2,3,4,4,4; `spm_as_`=1 once full; IF/ID constant. After release, PCs continue contiguously with no gap or repeat.
- `br_taken`, `br_addr`=32'h40, with 3 entries queued -> next edge: `fq_count`=0, `if_en`=0. Following edge: `if_pc`=32'h40.
- `flush` and `br_taken` together, `new_pc`=32'h100, `br_addr`=32'h200 -> target 32'h100. A misaligned `new_pc`=32'h103 fetches 32'h100.
- `reset` pulsed while `fq_count`=3 and `stall`=1 -> all outputs at reset values within the same cycle. Fetch restarts at RESET_VECTOR.
- Long random stall pattern, DEPTH=2 and DEPTH=8 -> the `if_pc` sequence of valid outputs is 0,4,8,… with no loss or duplication.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction-fetch stage with a prefetch queue.
//
// Fetches one word per cycle from SPM port A and feeds the IF/ID register,
// either directly (bypass, when the queue is empty and ID is accepting) or
// through a DEPTH-entry circular queue that keeps filling while ID stalls.
// flush and br_taken discard every in-flight fetch and redirect the fetch PC.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   stall                 hold the IF/ID register
//   flush, new_pc         redirect (highest priority) and its target
//   br_taken, br_addr     branch redirect and its target
//   spm_rd_data           SPM read data, valid in the strobe cycle
//   spm_addr, spm_as_     word address and active-low strobe (combinational)
//   spm_rw, spm_wr_data   constant read request, zero write data
//   if_pc, if_pc_plus4    PC (and PC+4) of the instruction in IF/ID
//   if_insn, if_en        instruction in IF/ID and its valid flag
//   fq_count              prefetch queue occupancy
module if_fetch_queue #(
   parameter int unsigned DEPTH        = 4,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           stall,
   input  logic                           flush,
   input  logic [31:0]                    new_pc,
   input  logic                           br_taken,
   input  logic [31:0]                    br_addr,
   input  logic [31:0]                    spm_rd_data,
   output logic [29:0]                    spm_addr,
   output logic                           spm_as_,
   output logic                           spm_rw,
   output logic [31:0]                    spm_wr_data,
   output logic [31:0]                    if_pc,
   output logic [31:0]                    if_pc_plus4,
   output logic [31:0]                    if_insn,
   output logic                           if_en,
   output logic [$clog2(DEPTH+1)-1:0]     fq_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic        READ  = 1'b1;

   logic [31:0]       fpc;
   logic [31:0]       q_pc   [DEPTH];
   logic [31:0]       q_insn [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              not_empty;
   logic              full;
   logic              pop;
   logic              issue;
   logic              bypass;
   logic              push;

   // Fetch/queue control; a full queue can still issue when ID pops the head
   always_comb begin
      redirect    = flush | br_taken;
      redirect_pc = (flush ? new_pc : br_addr) & 32'hFFFF_FFFC;
      not_empty   = (count != '0);
      full        = (count == CNT_W'(DEPTH));
      pop         = !stall && not_empty;
      issue       = !reset && !redirect && (!full || pop);
      bypass      = issue && !not_empty && !stall;
      push        = issue && !bypass;
   end

   // SPM port A request; strobe is dropped immediately while reset is high
   assign spm_addr    = fpc[31:2];
   assign spm_as_     = !issue;
   assign spm_rw      = READ;
   assign spm_wr_data = '0;
   assign fq_count    = count;

   // Fetch PC, queue and IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpc         <= RESET_VECTOR;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         if_pc       <= RESET_VECTOR;
         if_pc_plus4 <= RESET_VECTOR + 32'd4;
         if_insn     <= NOP_INSN;
         if_en       <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_pc[i]   <= '0;
            q_insn[i] <= '0;
         end
      end else if (redirect) begin
         // Discard everything in flight; IF/ID becomes a bubble, PC kept
         fpc     <= redirect_pc;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         if_insn <= NOP_INSN;
         if_en   <= 1'b0;
      end else begin
         if (issue) begin
            fpc <= fpc + 32'd4;
         end

         if (push) begin
            q_pc[wr_ptr]   <= fpc;
            q_insn[wr_ptr] <= spm_rd_data;
            wr_ptr         <= wr_ptr + PTR_W'(1);
         end

         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end

         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase

         // Queue head has priority over bypass to preserve fetch order
         if (!stall) begin
            if (not_empty) begin
               if_pc       <= q_pc[rd_ptr];
               if_pc_plus4 <= q_pc[rd_ptr] + 32'd4;
               if_insn     <= q_insn[rd_ptr];
               if_en       <= 1'b1;
            end else if (bypass) begin
               if_pc       <= fpc;
               if_pc_plus4 <= fpc + 32'd4;
               if_insn     <= spm_rd_data;
               if_en       <= 1'b1;
            end else begin
               if_insn <= NOP_INSN;
               if_en   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: three instances (DEPTH 2, 4, 8) share stimulus;
// each has its own SPM model. Directed checks target the DEPTH=4 instance,
// and a per-instance scoreboard checks fetch order on every valid output.
module tb_if_fetch_queue;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        br_taken;
   logic [31:0] br_addr;

   logic [31:0] rd     [3];
   logic [29:0] o_addr [3];
   logic        o_as   [3];
   logic        o_rw   [3];
   logic [31:0] o_wd   [3];
   logic [31:0] o_pc   [3];
   logic [31:0] o_pc4  [3];
   logic [31:0] o_insn [3];
   logic        o_en   [3];
   logic [1:0]  fq2;
   logic [2:0]  fq4;
   logic [3:0]  fq8;

   logic [31:0] q0 [$];
   logic [31:0] q1 [$];
   logic [31:0] q2 [$];
   int          pops [3];

   int checks = 0;
   int errors = 0;

   // SPM contents: the two test-plan words, then a unique word per address
   function automatic logic [31:0] insn_of(input logic [31:0] pc);
      if (pc == 32'h0) return 32'h0040_0093;
      if (pc == 32'h4) return 32'h4010_2023;
      return pc ^ 32'hA500_0000;
   endfunction

   assign rd[0] = insn_of({o_addr[0], 2'b00});
   assign rd[1] = insn_of({o_addr[1], 2'b00});
   assign rd[2] = insn_of({o_addr[2], 2'b00});

   if_fetch_queue #(.DEPTH(2)) u2 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
      .br_taken(br_taken), .br_addr(br_addr), .spm_rd_data(rd[0]),
      .spm_addr(o_addr[0]), .spm_as_(o_as[0]), .spm_rw(o_rw[0]), .spm_wr_data(o_wd[0]),
      .if_pc(o_pc[0]), .if_pc_plus4(o_pc4[0]), .if_insn(o_insn[0]), .if_en(o_en[0]),
      .fq_count(fq2));

   if_fetch_queue #(.DEPTH(4)) u4 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
      .br_taken(br_taken), .br_addr(br_addr), .spm_rd_data(rd[1]),
      .spm_addr(o_addr[1]), .spm_as_(o_as[1]), .spm_rw(o_rw[1]), .spm_wr_data(o_wd[1]),
      .if_pc(o_pc[1]), .if_pc_plus4(o_pc4[1]), .if_insn(o_insn[1]), .if_en(o_en[1]),
      .fq_count(fq4));

   if_fetch_queue #(.DEPTH(8)) u8 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
      .br_taken(br_taken), .br_addr(br_addr), .spm_rd_data(rd[2]),
      .spm_addr(o_addr[2]), .spm_as_(o_as[2]), .spm_rw(o_rw[2]), .spm_wr_data(o_wd[2]),
      .if_pc(o_pc[2]), .if_pc_plus4(o_pc4[2]), .if_insn(o_insn[2]), .if_en(o_en[2]),
      .fq_count(fq8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected output stream after a reset or redirect: target, target+4, ...
   task automatic sb_restart(input logic [31:0] target);
      q0.delete();
      q1.delete();
      q2.delete();
      for (int i = 0; i < 800; i++) begin
         q0.push_back(target + 32'(4 * i));
         q1.push_back(target + 32'(4 * i));
         q2.push_back(target + 32'(4 * i));
      end
   endtask

   // A new instruction entered IF/ID iff stall was low at the edge and if_en=1
   task automatic sb_one(input int k);
      logic [31:0] exp;
      if (!stall && o_en[k] === 1'b1) begin
         exp = 32'hDEAD_BEEF;
         case (k)
            0: if (q0.size() > 0) exp = q0.pop_front();
            1: if (q1.size() > 0) exp = q1.pop_front();
            default: if (q2.size() > 0) exp = q2.pop_front();
         endcase
         pops[k]++;
         chk($sformatf("sb%0d_pc", k), o_pc[k], exp);
         chk($sformatf("sb%0d_insn", k), o_insn[k], insn_of(exp));
         chk($sformatf("sb%0d_pc4", k), o_pc4[k], exp + 32'd4);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      sb_one(0);
      sb_one(1);
      sb_one(2);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},   o_pc[1], 32'h0);
      chk({tag, "_pc4"},  o_pc4[1], 32'h4);
      chk({tag, "_insn"}, o_insn[1], NOP);
      chk({tag, "_en"},   32'(o_en[1]), 32'h0);
      chk({tag, "_fq"},   32'(fq4), 32'h0);
      chk({tag, "_as"},   32'(o_as[1]), 32'h1);
   endtask

   initial begin
      pops     = '{0, 0, 0};
      reset    = 1'b1;
      stall    = 1'b0;
      flush    = 1'b0;
      br_taken = 1'b0;
      new_pc   = '0;
      br_addr  = '0;
      #2;
      chk_reset_vals("rst");
      chk("rw",  32'(o_rw[1]), 32'h1);
      chk("wd",  o_wd[1], 32'h0);
      @(posedge clk);
      #1;

      // Reset release: bypass path, one instruction per edge
      reset = 1'b0;
      sb_restart(32'h0);
      step();
      chk("e1_pc",   o_pc[1], 32'h0);
      chk("e1_insn", o_insn[1], 32'h0040_0093);
      chk("e1_en",   32'(o_en[1]), 32'h1);
      step();
      chk("e2_pc",   o_pc[1], 32'h4);
      chk("e2_pc4",  o_pc4[1], 32'h8);
      chk("e2_insn", o_insn[1], 32'h4010_2023);

      // Stall for 6 cycles: queue fills to DEPTH then the strobe stops
      stall = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         chk($sformatf("stall%0d_fq", i), 32'(fq4), (i < 4) ? 32'(i) : 32'd4);
         chk($sformatf("stall%0d_as", i), 32'(o_as[1]), (i < 4) ? 32'h0 : 32'h1);
         chk($sformatf("stall%0d_pc", i), o_pc[1], 32'h4);
         chk($sformatf("stall%0d_insn", i), o_insn[1], 32'h4010_2023);
      end
      chk("full_addr", 32'(o_addr[1]), 32'd6);

      // Unstall on a full queue: pop and issue together, count stays full
      stall = 1'b0;
      #1;
      chk("unstall_as", 32'(o_as[1]), 32'h0);
      step();
      chk("unstall_fq", 32'(fq4), 32'd4);
      step();
      step();

      // Flush to a misaligned target fetches the aligned word
      flush  = 1'b1;
      new_pc = 32'h103;
      sb_restart(32'h100);
      step();
      flush = 1'b0;
      chk("fl_en",   32'(o_en[1]), 32'h0);
      chk("fl_insn", o_insn[1], NOP);
      chk("fl_fq",   32'(fq4), 32'h0);
      step();
      chk("fl_pc",   o_pc[1], 32'h100);
      chk("fl_en2",  32'(o_en[1]), 32'h1);

      // Branch with 3 entries queued, while stalled
      stall = 1'b1;
      step();
      step();
      step();
      chk("pre_br_fq", 32'(fq4), 32'd3);
      br_taken = 1'b1;
      br_addr  = 32'h40;
      sb_restart(32'h40);
      step();
      br_taken = 1'b0;
      stall    = 1'b0;
      chk("br_fq", 32'(fq4), 32'h0);
      chk("br_en", 32'(o_en[1]), 32'h0);
      step();
      chk("br_pc", o_pc[1], 32'h40);
      chk("br_en2", 32'(o_en[1]), 32'h1);

      // flush wins over br_taken
      flush    = 1'b1;
      br_taken = 1'b1;
      new_pc   = 32'h100;
      br_addr  = 32'h200;
      sb_restart(32'h100);
      step();
      flush    = 1'b0;
      br_taken = 1'b0;
      chk("fb_en", 32'(o_en[1]), 32'h0);
      step();
      chk("fb_pc", o_pc[1], 32'h100);

      // Reset pulse with 3 queued entries under stall
      stall = 1'b1;
      step();
      step();
      step();
      chk("pre_rst_fq", 32'(fq4), 32'd3);
      reset = 1'b1;
      #1;
      chk_reset_vals("mid_rst");
      sb_restart(32'h0);
      step();
      reset = 1'b0;
      stall = 1'b0;
      step();
      chk("rst_pc", o_pc[1], 32'h0);
      chk("rst_en", 32'(o_en[1]), 32'h1);

      // Random stall pattern; scoreboards check order on all depths
      for (int i = 0; i < 600; i++) begin
         stall = ($urandom_range(0, 99) < 55);
         step();
      end
      stall = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("progress2", 32'(pops[0] > 200), 32'h1);
      chk("progress8", 32'(pops[2] > 200), 32'h1);
      chk("same_pops", 32'(pops[0]), 32'(pops[2]));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
